masked_state_matrix_buffer: RTL and testbench
=============================================

Name: masked_state_matrix_buffer

Overview:
Sequential, share-aware state buffer for the masked AES datapath. It accepts a serial stream of shared elements in column-major order and assembles them into a ROWS x COLS matrix. The matrix is exposed as a flat vector and can be rotated in place (ShiftRows). Contents then drain serially over a valid/ready handshake. It generalises the fixed 128-bit to 4x4 byte matrix mapping in element width, geometry and share count, and adds buffering, handshakes and row rotation.

Parameters:
NSHARES, 2, number of Boolean shares per element (>=1)
ELEM_W, 8, bits per element share
ROWS, 4, matrix rows (>=2)
COLS, 4, matrix columns (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input element valid
in_ready  out  1  buffer accepts input element
in_data  in  NSHARES*ELEM_W  share s at bits [(s+1)*ELEM_W-1 : s*ELEM_W]
matrix_valid  out  1  matrix complete (FULL state)
matrix_flat  out  NSHARES*ROWS*COLS*ELEM_W  full matrix view, layout below
rot_req  in  1  one-cycle ShiftRows request, honoured only in FULL
drain_start  in  1  begin serial unload, honoured only in FULL
out_valid  out  1  output element valid
out_ready  in  1  sink accepts output element
out_data  out  NSHARES*ELEM_W  same share packing as in_data

Behaviour:
- Reset and clocking: single clock domain. Reset is asynchronous and active-low on rst_n.
- Reset state: all storage cleared to 0, idx=0, state=IDLE. All outputs are 0 during reset and in IDLE.
- Element order: element index k = c*ROWS + r (0-based r, c). k=0 is row1/col1, k=1 is row2/col1, and so on.
- matrix_flat layout:
  - Share s occupies block [(s+1)*B-1 : s*B], where B = ROWS*COLS*ELEM_W.
  - Element k of share s sits at block offset [B-1-k*ELEM_W -: ELEM_W] (MSB-first).
  - For ROWS=COLS=4, ELEM_W=8 this is the AES column-major byte mapping: byte 0 at [127:120].
- Counter: idx is $clog2(ROWS*COLS) bits wide, range 0..ROWS*COLS-1. It is cleared on every state change.
- FSM:
  - IDLE -> LOAD unconditionally on the first cycle after reset release.
  - LOAD:
    - in_ready=1.
    - On in_valid&&in_ready, store in_data into element idx, then idx++.
    - When the last element (idx=ROWS*COLS-1) is accepted, go to FULL.
  - FULL:
    - matrix_valid=1, in_ready=0.
    - rot_req: rotate row r left by r positions, identically and independently in every share (share-wise linear, no share mixing). Done in one cycle; matrix_flat updates on the next cycle.
    - drain_start: go to DRAIN.
    - rot_req and drain_start in the same cycle: both take effect. The first drained element comes from the rotated matrix.
  - DRAIN:
    - out_valid=1, out_data = element idx (all shares).
    - idx++ on out_valid&&out_ready.
    - When the last element is accepted, go to LOAD.
    - rot_req and drain_start are ignored.
- Latency:
  - Last input accepted -> matrix_valid at next cycle.
  - drain_start -> out_valid at next cycle.
  - Last output accepted -> in_ready at next cycle.
- Backpressure: while out_valid && !out_ready, out_data and idx hold stable. in_data is sampled only on handshake.
- Outputs: matrix_flat is registered storage and is always visible. Its contents are meaningful only while matrix_valid=1.
- rot_req or drain_start outside FULL: no effect, no error.
- Reset mid-operation (any state): immediate clear to the reset state. Partial data is discarded.

Optional Feature:
Macro STATE_ROT_INV_EN.
- Defined: adds input port rot_inv (1 bit). When rot_req is taken with rot_inv=1, row r rotates right by r (InvShiftRows); rot_inv=0 gives the left rotation.
- Undefined: rot_inv port is absent; only left rotation is available.

Decomposition:
- Package tsm_state_pkg:
  - FSM state enum (IDLE, LOAD, FULL, DRAIN).
  - Function elem_index(r, c).
  - Function flat_offset(s, k).
  - Constant NELEM = ROWS*COLS.
- Sub-module state_row_rotator: purely combinational, one share-matrix in and rotated matrix out, with parameters ELEM_W/ROWS/COLS and direction input. Instantiated NSHARES times.

Test Plan:
- Load 16 bytes 0x00..0x0F (share0), share1 = 0xA5 each -> matrix_valid after the 16th handshake. share0 block = 0x000102..0F, [127:120]=0x00. share1 block all 0xA5.
- FULL with rot_req on the 0x00..0x0F matrix -> share0 rows become (00,04,08,0C), (05,09,0D,01), (0A,0E,02,06), (0F,03,07,0B). share1 unchanged.
- drain_start with out_ready toggling 1,0,0,1 -> out_data holds across stall cycles; exactly 16 elements, in order 0x00..0x0F; in_ready=1 the cycle after the last one.
- rot_req and drain_start in the same cycle -> first out_data = 0x00, second = 0x05 (rotated order).
- rst_n low after 7 loaded elements -> all outputs 0 immediately; reload of 16 elements yields only the new data.
- STATE_ROT_INV_EN defined, rot_req with rot_inv=1 on the rotated matrix -> original 0x00..0x0F restored. Also rerun with NSHARES=3, ELEM_W=4, ROWS=COLS=2.

Source files
------------

// File: rtl/masked_state_matrix_buffer_pkg.sv
// Shared FSM state type, default geometry and element/bit-offset helpers
// for the masked state matrix buffer and its row rotator.
package tsm_state_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int ROWS_DEF = 4;
    localparam int COLS_DEF = 4;
    localparam int NELEM    = ROWS_DEF * COLS_DEF;

    // Column-major element number of row r, column c.
    function automatic int elem_index(input int r, input int c, input int rows);
        return (c * rows) + r;
    endfunction

    // MSB bit position of element k of share s in the flat matrix vector.
    function automatic int flat_offset(input int s, input int k, input int elem_w, input int nelem);
        return ((s + 1) * nelem * elem_w) - 1 - (k * elem_w);
    endfunction

endpackage

// File: rtl/masked_state_matrix_buffer_if.sv
// Handshake and matrix-view bundle of the masked state matrix buffer.
// Optional macro STATE_ROT_INV_EN adds the rot_inv direction select.
interface masked_state_matrix_buffer_if #(
    parameter int NSHARES = 2,
    parameter int ELEM_W  = 8,
    parameter int ROWS    = 4,
    parameter int COLS    = 4
);
    logic                                in_valid;
    logic                                in_ready;
    logic [NSHARES*ELEM_W-1:0]           in_data;
    logic                                matrix_valid;
    logic [NSHARES*ROWS*COLS*ELEM_W-1:0] matrix_flat;
    logic                                rot_req;
    logic                                drain_start;
    logic                                out_valid;
    logic                                out_ready;
    logic [NSHARES*ELEM_W-1:0]           out_data;
`ifdef STATE_ROT_INV_EN
    logic                                rot_inv;

    modport master (
        output in_valid, in_data, rot_req, drain_start, out_ready, rot_inv,
        input  in_ready, matrix_valid, matrix_flat, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, rot_req, drain_start, out_ready, rot_inv,
        output in_ready, matrix_valid, matrix_flat, out_valid, out_data
    );
`else
    modport master (
        output in_valid, in_data, rot_req, drain_start, out_ready,
        input  in_ready, matrix_valid, matrix_flat, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, rot_req, drain_start, out_ready,
        output in_ready, matrix_valid, matrix_flat, out_valid, out_data
    );
`endif
endinterface

// File: rtl/masked_state_matrix_buffer_rotator.sv
// Combinational ShiftRows / InvShiftRows on one share-matrix: row r rotates
// left (dir=0) or right (dir=1) by r positions; pure wiring plus a 2:1 mux.
module state_row_rotator
    import tsm_state_pkg::*;
#(
    parameter int ELEM_W = 8,
    parameter int ROWS   = 4,
    parameter int COLS   = 4
) (
    input  logic [ROWS*COLS*ELEM_W-1:0] mat_in,
    input  logic                        dir,
    output logic [ROWS*COLS*ELEM_W-1:0] mat_out
);

    localparam int NE = ROWS * COLS;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int DST   = flat_offset(0, elem_index(r, c, ROWS), ELEM_W, NE);
            localparam int SRC_L = flat_offset(0, elem_index(r, (c + r) % COLS, ROWS), ELEM_W, NE);
            localparam int SRC_R = flat_offset(0, elem_index(r, (c + COLS - (r % COLS)) % COLS, ROWS),
                                               ELEM_W, NE);

            assign mat_out[DST -: ELEM_W] = dir ? mat_in[SRC_R -: ELEM_W] : mat_in[SRC_L -: ELEM_W];
        end
    end

endmodule

// File: rtl/masked_state_matrix_buffer.sv
// Share-aware state buffer: serial column-major load, in-place row rotation,
// serial drain. Optional macro STATE_ROT_INV_EN enables inverse rotation.
module masked_state_matrix_buffer
    import tsm_state_pkg::*;
#(
    parameter int NSHARES = 2,
    parameter int ELEM_W  = 8,
    parameter int ROWS    = ROWS_DEF,
    parameter int COLS    = COLS_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    masked_state_matrix_buffer_if.slave  bus
);

    localparam int NE    = ROWS * COLS;
    localparam int B     = NE * ELEM_W;
    localparam int W     = NSHARES * B;
    localparam int DW    = NSHARES * ELEM_W;
    localparam int IDX_W = $clog2(NE);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_e           state_r;
    state_e           state_n;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_n;
    logic [W-1:0]     matrix_r;
    logic [W-1:0]     matrix_n;
    logic [W-1:0]     rotated_s;
    logic [DW-1:0]    out_data_r;
    logic [DW-1:0]    out_data_n;
    logic             in_ready_r;
    logic             matrix_valid_r;
    logic             out_valid_r;
    logic             rot_dir_s;

`ifdef STATE_ROT_INV_EN
    assign rot_dir_s = bus.rot_inv;
`else
    assign rot_dir_s = 1'b0;
`endif

    for (genvar s = 0; s < NSHARES; s++) begin : g_share
        state_row_rotator #(
            .ELEM_W (ELEM_W),
            .ROWS   (ROWS),
            .COLS   (COLS)
        ) u_rot (
            .mat_in  (matrix_r[s*B +: B]),
            .dir     (rot_dir_s),
            .mat_out (rotated_s[s*B +: B])
        );
    end

    // Next state, element index, storage update and next output element.
    always_comb begin
        state_n    = state_r;
        idx_n      = idx_r;
        matrix_n   = matrix_r;
        out_data_n = '0;
        case (state_r)
            IDLE: begin
                state_n = LOAD;
                idx_n   = '0;
            end
            LOAD: begin
                if (bus.in_valid) begin
                    for (int s = 0; s < NSHARES; s++) begin
                        matrix_n[flat_offset(s, int'(idx_r), ELEM_W, NE) -: ELEM_W] =
                            bus.in_data[s*ELEM_W +: ELEM_W];
                    end
                    if (idx_r == IDX_LAST) begin
                        state_n = FULL;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx_r + IDX_ONE;
                    end
                end else begin
                    idx_n = idx_r;
                end
            end
            FULL: begin
                // Rotation and drain start may coincide; the drain then reads the rotated matrix.
                if (bus.rot_req) begin
                    matrix_n = rotated_s;
                end else begin
                    matrix_n = matrix_r;
                end
                if (bus.drain_start) begin
                    state_n = DRAIN;
                    idx_n   = '0;
                end else begin
                    state_n = FULL;
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    if (idx_r == IDX_LAST) begin
                        state_n = LOAD;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx_r + IDX_ONE;
                    end
                end else begin
                    idx_n = idx_r;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase

        // out_data is registered, so it is fetched from the next-cycle storage and index.
        if (state_n == DRAIN) begin
            for (int s = 0; s < NSHARES; s++) begin
                out_data_n[s*ELEM_W +: ELEM_W] =
                    matrix_n[flat_offset(s, int'(idx_n), ELEM_W, NE) -: ELEM_W];
            end
        end else begin
            out_data_n = '0;
        end
    end

    // State, storage and registered status/output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            idx_r          <= '0;
            matrix_r       <= '0;
            out_data_r     <= '0;
            in_ready_r     <= 1'b0;
            matrix_valid_r <= 1'b0;
            out_valid_r    <= 1'b0;
        end else begin
            state_r        <= state_n;
            idx_r          <= idx_n;
            matrix_r       <= matrix_n;
            out_data_r     <= out_data_n;
            in_ready_r     <= (state_n == LOAD);
            matrix_valid_r <= (state_n == FULL);
            out_valid_r    <= (state_n == DRAIN);
        end
    end

    assign bus.in_ready     = in_ready_r;
    assign bus.matrix_valid = matrix_valid_r;
    assign bus.matrix_flat  = matrix_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_data     = out_data_r;

endmodule

// File: tb/tb_masked_state_matrix_buffer.sv
// Directed self-checking bench: default 2-share 4x4 byte build plus a
// 3-share 2x2 nibble build sharing clock and reset.
module tb_masked_state_matrix_buffer;
    import tsm_state_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    masked_state_matrix_buffer_if #(.NSHARES(2), .ELEM_W(8), .ROWS(4), .COLS(4)) bus ();
    masked_state_matrix_buffer_if #(.NSHARES(3), .ELEM_W(4), .ROWS(2), .COLS(2)) sbus ();

    masked_state_matrix_buffer #(.NSHARES(2), .ELEM_W(8), .ROWS(4), .COLS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    masked_state_matrix_buffer #(.NSHARES(3), .ELEM_W(4), .ROWS(2), .COLS(2)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    logic [7:0]   rot_order [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                                     8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
    logic [127:0] plain_blk = 128'h000102030405060708090A0B0C0D0E0F;
    logic [127:0] rot_blk   = 128'h00050A0F04090E03080D02070C01060B;
    int           pat [4]   = '{1, 0, 0, 1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_elem(input logic [15:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic load_full(input logic [7:0] base, input logic [7:0] sh1);
        for (int k = 0; k < NELEM; k++) load_elem({sh1, base + 8'(k)});
    endtask

    task automatic drain_all();
        bus.drain_start = 1'b1;
        tick();
        bus.drain_start = 1'b0;
        bus.out_ready   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!bus.out_valid) break;
            tick();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else n_pass++;
        n_checks++; if (bus.matrix_valid !== 1'b0) $display("FAIL reset_matrix_valid: got %b want 0", bus.matrix_valid); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 16'h0) $display("FAIL reset_out_data: got %h want 0", bus.out_data); else n_pass++;
        n_checks++; if (bus.matrix_flat !== 256'h0) $display("FAIL reset_flat: got %h want 0", bus.matrix_flat); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL load_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_load();
        for (int k = 0; k < NELEM - 1; k++) load_elem({8'hA5, 8'(k)});
        n_checks++; if (bus.matrix_valid !== 1'b0) $display("FAIL early_matrix_valid: got %b want 0", bus.matrix_valid); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL load15_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        load_elem({8'hA5, 8'h0F});
        n_checks++; if (bus.matrix_valid !== 1'b1) $display("FAIL full_matrix_valid: got %b want 1", bus.matrix_valid); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", bus.in_ready); else n_pass++;
        n_checks++;
        if (bus.matrix_flat !== {{16{8'hA5}}, plain_blk}) $display("FAIL load_flat: got %h want %h", bus.matrix_flat, {{16{8'hA5}}, plain_blk});
        else n_pass++;
    endtask

    task automatic test_drain_backpressure();
        int e = 0;
        int j = 0;
        bus.drain_start = 1'b1;
        tick();
        bus.drain_start = 1'b0;
        while (e < NELEM && j < 100) begin
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL drain_valid e=%0d: got %b want 1", e, bus.out_valid); else n_pass++;
            n_checks++;
            if (bus.out_data !== {8'hA5, 8'(e)}) $display("FAIL drain_data e=%0d: got %h want %h", e, bus.out_data, {8'hA5, 8'(e)});
            else n_pass++;
            bus.out_ready = pat[j % 4][0];
            tick();
            if (bus.out_ready) e++;
            j++;
        end
        bus.out_ready = 1'b0;
        n_checks++; if (e !== NELEM) $display("FAIL drain_count: got %0d want %0d", e, NELEM); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL drain_end_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL drain_end_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_rotate();
        load_full(8'h00, 8'hA5);
        bus.rot_req = 1'b1;
        tick();
        bus.rot_req = 1'b0;
        n_checks++;
        if (bus.matrix_flat !== {{16{8'hA5}}, rot_blk}) $display("FAIL rot_flat: got %h want %h", bus.matrix_flat, {{16{8'hA5}}, rot_blk});
        else n_pass++;
        n_checks++; if (bus.matrix_valid !== 1'b1) $display("FAIL rot_matrix_valid: got %b want 1", bus.matrix_valid); else n_pass++;
`ifdef STATE_ROT_INV_EN
        bus.rot_req = 1'b1;
        bus.rot_inv = 1'b1;
        tick();
        bus.rot_req = 1'b0;
        bus.rot_inv = 1'b0;
        n_checks++;
        if (bus.matrix_flat !== {{16{8'hA5}}, plain_blk}) $display("FAIL inv_rot_flat: got %h want %h", bus.matrix_flat, {{16{8'hA5}}, plain_blk});
        else n_pass++;
`endif
        drain_all();
    endtask

    task automatic test_rot_and_drain();
        load_full(8'h00, 8'hA5);
        bus.rot_req     = 1'b1;
        bus.drain_start = 1'b1;
        tick();
        bus.rot_req     = 1'b0;
        bus.drain_start = 1'b0;
        for (int e = 0; e < NELEM; e++) begin
            n_checks++;
            if (bus.out_data !== {8'hA5, rot_order[e]}) $display("FAIL rotdrain_data e=%0d: got %h want %h", e, bus.out_data, {8'hA5, rot_order[e]});
            else n_pass++;
            bus.out_ready = 1'b1;
            tick();
        end
        bus.out_ready = 1'b0;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rotdrain_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        for (int k = 0; k < 7; k++) load_elem({8'h3C, 8'h40 + 8'(k)});
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.matrix_flat !== 256'h0) $display("FAIL midrst_flat: got %h want 0", bus.matrix_flat); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b want 0", bus.in_ready); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        bus.rot_req     = 1'b1;
        bus.drain_start = 1'b1;
        tick();
        bus.rot_req     = 1'b0;
        bus.drain_start = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL ignored_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL ignored_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.matrix_flat !== 256'h0) $display("FAIL ignored_flat: got %h want 0", bus.matrix_flat); else n_pass++;
        load_full(8'h10, 8'h3C);
        n_checks++;
        if (bus.matrix_flat !== {{16{8'h3C}}, 128'h101112131415161718191A1B1C1D1E1F})
            $display("FAIL reload_flat: got %h want %h", bus.matrix_flat, {{16{8'h3C}}, 128'h101112131415161718191A1B1C1D1E1F});
        else n_pass++;
        drain_all();
    endtask

    task automatic test_small_geometry();
        logic [11:0] exp_s [4] = '{12'h840, 12'hB73, 12'hA62, 12'h951};
        for (int k = 0; k < 4; k++) begin
            sbus.in_valid = 1'b1;
            sbus.in_data  = {4'(k + 8), 4'(k + 4), 4'(k)};
            tick();
        end
        sbus.in_valid = 1'b0;
        n_checks++; if (sbus.matrix_valid !== 1'b1) $display("FAIL small_matrix_valid: got %b want 1", sbus.matrix_valid); else n_pass++;
        n_checks++; if (sbus.matrix_flat !== 48'h89AB_4567_0123) $display("FAIL small_flat: got %h want 89ab45670123", sbus.matrix_flat); else n_pass++;
        sbus.rot_req = 1'b1;
        tick();
        sbus.rot_req = 1'b0;
        n_checks++; if (sbus.matrix_flat !== 48'h8BA9_4765_0321) $display("FAIL small_rot_flat: got %h want 8ba947650321", sbus.matrix_flat); else n_pass++;
        sbus.drain_start = 1'b1;
        tick();
        sbus.drain_start = 1'b0;
        for (int e = 0; e < 4; e++) begin
            n_checks++;
            if (sbus.out_data !== exp_s[e]) $display("FAIL small_drain e=%0d: got %h want %h", e, sbus.out_data, exp_s[e]);
            else n_pass++;
            sbus.out_ready = 1'b1;
            tick();
        end
        sbus.out_ready = 1'b0;
        n_checks++; if (sbus.in_ready !== 1'b1) $display("FAIL small_in_ready: got %b want 1", sbus.in_ready); else n_pass++;
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_data      = 16'h0;
        bus.rot_req      = 1'b0;
        bus.drain_start  = 1'b0;
        bus.out_ready    = 1'b0;
        sbus.in_valid    = 1'b0;
        sbus.in_data     = 12'h0;
        sbus.rot_req     = 1'b0;
        sbus.drain_start = 1'b0;
        sbus.out_ready   = 1'b0;
`ifdef STATE_ROT_INV_EN
        bus.rot_inv      = 1'b0;
        sbus.rot_inv     = 1'b0;
`endif
        test_reset();
        test_load();
        test_drain_backpressure();
        test_rotate();
        test_rot_and_drain();
        test_reset_mid_load();
        test_small_geometry();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
